dm_port_arbiter: RTL and testbench

//  Shares the single data-memory port (addr/wdata/byteen/rdata, combinational read, posedge write) between
//  the CPU M-stage and an auxiliary requester (loader/DMA). CPU normally wins; a starvation counter forces an
//  aux grant after MAX_WAIT lost cycles, stalling the CPU for that cycle. Sits between mips and data memory.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_wait_ctr.sv | 42 ++++
 rtl/dm_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_pkg
// Purpose  : Grant encodings and address helpers shared by the data-memory
//            port arbiter and its starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

  localparam logic [1:0]  GNT_NONE        = 2'd0;
  localparam logic [1:0]  GNT_CPU         = 2'd1;
  localparam logic [1:0]  GNT_AUX         = 2'd2;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hffff_fffc;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_arb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_wait_ctr
// Purpose  : Saturating starvation counter; at_limit flags count >= MAX_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arb_wait_ctr
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  generate
    if (MAX_WAIT == 0) begin : g_no_wait
      // Aux always wins conflicts, so no count needs to be kept.
      assign at_limit = 1'b1;
    end else begin : g_count
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (inc && (r_cnt != {CW{1'b1}})) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign at_limit = (r_cnt >= CW'(MAX_WAIT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Shares one data-memory port between the CPU M-stage and an aux
//            requester; CPU wins unless aux has starved for MAX_WAIT cycles.
//            Define DM_ARB_STAT_EN to add conflict / forced-grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int DEPTH    = 4096,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic [3:0]  aux_byteen,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        aux_err,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
`ifdef DM_ARB_STAT_EN
  ,
  output logic [31:0] stat_conflict,
  output logic [31:0] stat_forced
`endif
);

  localparam logic [32:0] c_addr_limit = 33'(DEPTH) << 2;

  logic [1:0]  w_grant;
  logic        w_at_limit;
  logic        w_accept;
  logic        w_in_range;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_byteen;
  logic [31:0] w_rd_word;

  logic        r_aux_rvalid;
  logic [31:0] r_aux_rdata;
  logic        r_aux_err;

  always_comb begin
    w_grant = GNT_NONE;
    if (!reset) begin
      if (aux_valid && (!cpu_req || w_at_limit)) begin
        w_grant = GNT_AUX;
      end else if (cpu_req) begin
        w_grant = GNT_CPU;
      end
    end
  end

  always_comb begin
    w_sel_addr   = 32'h0;
    w_sel_wdata  = 32'h0;
    w_sel_byteen = 4'h0;
    case (w_grant)
      GNT_CPU: begin
        w_sel_addr   = cpu_addr;
        w_sel_wdata  = cpu_wdata;
        w_sel_byteen = cpu_byteen;
      end
      GNT_AUX: begin
        w_sel_addr   = aux_addr;
        w_sel_wdata  = aux_wdata;
        w_sel_byteen = aux_byteen;
      end
      default: ;
    endcase
  end

  // Out-of-range accesses never touch memory and read back as zero.
  assign w_in_range    = ({1'b0, w_sel_addr} < c_addr_limit);
  assign w_rd_word     = w_in_range ? m_data_rdata : 32'h0;
  assign m_data_addr   = word_addr(w_sel_addr);
  assign m_data_wdata  = w_sel_wdata;
  assign m_data_byteen = w_in_range ? w_sel_byteen : 4'h0;

  assign cpu_rdata = (w_grant == GNT_CPU) ? w_rd_word : 32'h0;
  assign cpu_stall = cpu_req && !reset && (w_grant != GNT_CPU);
  assign aux_ready = (w_grant == GNT_AUX);
  assign w_accept  = aux_valid && aux_ready;

  dm_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (aux_valid && !aux_ready),
    .clr      (!aux_valid || w_accept),
    .at_limit (w_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= 32'h0;
      r_aux_err    <= 1'b0;
    end else begin
      r_aux_rvalid <= w_accept;
      r_aux_err    <= w_accept && !w_in_range;
      if (w_accept) begin
        r_aux_rdata <= w_rd_word;
      end
    end
  end

  assign aux_rvalid = r_aux_rvalid;
  assign aux_rdata  = r_aux_rdata;
  assign aux_err    = r_aux_err;

`ifdef DM_ARB_STAT_EN
  logic [31:0] r_stat_conflict;
  logic [31:0] r_stat_forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_conflict <= 32'h0;
      r_stat_forced   <= 32'h0;
    end else begin
      if (cpu_req && aux_valid) begin
        r_stat_conflict <= r_stat_conflict + 32'd1;
      end
      if (w_accept && cpu_req) begin
        r_stat_forced <= r_stat_forced + 32'd1;
      end
    end
  end

  assign stat_conflict = r_stat_conflict;
  assign stat_forced   = r_stat_forced;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Self-checking bench for dm_port_arbiter with a memory model and
//            an aux response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 4096;
  localparam int CW       = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_valid;
  logic        aux_ready;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic [3:0]  aux_byteen;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        aux_err;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
`ifdef DM_ARB_STAT_EN
  logic [31:0] stat_conflict;
  logic [31:0] stat_forced;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem    [0:DEPTH-1];
  logic [31:0] shadow [0:DEPTH-1];

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .DEPTH    (DEPTH),
    .CW       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_byteen    (cpu_byteen),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .aux_valid     (aux_valid),
    .aux_ready     (aux_ready),
    .aux_addr      (aux_addr),
    .aux_wdata     (aux_wdata),
    .aux_byteen    (aux_byteen),
    .aux_rvalid    (aux_rvalid),
    .aux_rdata     (aux_rdata),
    .aux_err       (aux_err),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata)
`ifdef DM_ARB_STAT_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_forced   (stat_forced)
`endif
  );

  // Data memory: combinational read, byte-lane write on posedge.
  assign m_data_rdata = mem[m_data_addr[13:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m_data_byteen[b]) mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Push the expected response for the aux request being accepted now.
  task automatic note_accept();
    exp_t e;
    int   idx;
    logic inr;
    inr     = (aux_addr < 32'(DEPTH * 4));
    idx     = int'(aux_addr[13:2]);
    e.rdata = inr ? shadow[idx] : 32'h0;
    e.err   = !inr;
    exp_q.push_back(e);
    if (inr) shadow[idx] = merge(shadow[idx], aux_wdata, aux_byteen);
  endtask

  always @(negedge clk) begin
    if (aux_rvalid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL aux_rvalid_unexpected: got rvalid=1 rdata=%h err=%b, required no response",
                 aux_rdata, aux_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (aux_rdata !== mon_e.rdata || aux_err !== mon_e.err) begin
          n_fail++;
          $display("FAIL aux_response: got rdata=%h err=%b, required rdata=%h err=%b",
                   aux_rdata, aux_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  task automatic run_aux(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input int limit, output int at);
    aux_valid  = 1'b1;
    aux_addr   = a;
    aux_wdata  = d;
    aux_byteen = be;
    at         = 0;
    for (int c = 1; c <= limit && at == 0; c++) begin
      @(negedge clk);
      n_tests++;
      if (aux_ready === 1'b1) begin
        at = c;
        note_accept();
        if (cpu_stall !== cpu_req || (cpu_req && cpu_rdata !== 32'h0)) begin
          n_fail++;
          $display("FAIL stall_on_aux_grant: got stall=%b cpu_rdata=%h, required stall=%b rdata=0",
                   cpu_stall, cpu_rdata, cpu_req);
        end
      end else if (cpu_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_on_cpu_grant: got stall=%b, required 0", cpu_stall);
      end
      @(posedge clk); #1;
    end
    if (at == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL aux_timeout: got no aux_ready in %0d cycles, required a grant", limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111; cpu_byteen = 4'hf;
    aux_valid = 1'b1; aux_addr = 32'h14; aux_wdata = 32'h2222_2222; aux_byteen = 4'hf;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_stall !== 1'b0 || aux_ready !== 1'b0 || aux_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_handshake: got stall=%b ready=%b rvalid=%b, required 0 0 0",
                 cpu_stall, aux_ready, aux_rvalid);
      end
      n_tests++;
      if (m_data_addr !== 32'h0 || m_data_byteen !== 4'h0 || m_data_wdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mem_mux: got addr=%h be=%h wdata=%h, required 0 0 0",
                 m_data_addr, m_data_byteen, m_data_wdata);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; cpu_req = 1'b0; cpu_byteen = 4'h0; aux_valid = 1'b0; aux_byteen = 4'h0;
    @(negedge clk);
    n_tests++;
    if (mem[4] !== 32'h0 || mem[5] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_no_write: got mem4=%h mem5=%h, required 0 0", mem[4], mem[5]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hdead_beef; cpu_byteen = 4'hf;
    @(negedge clk);
    n_tests++;
    if (cpu_stall !== 1'b0 || m_data_addr !== 32'h10 || m_data_byteen !== 4'hf) begin
      n_fail++;
      $display("FAIL cpu_write_grant: got stall=%b addr=%h be=%h, required 0 00000010 f",
               cpu_stall, m_data_addr, m_data_byteen);
    end
    shadow[4] = 32'hdead_beef;
    @(posedge clk); #1;
    cpu_addr = 32'h13; cpu_byteen = 4'h0;
    @(negedge clk);
    n_tests++;
    if (mem[4] !== 32'hdead_beef) begin
      n_fail++;
      $display("FAIL cpu_write_mem: got %h, required deadbeef", mem[4]);
    end
    n_tests++;
    if (cpu_rdata !== 32'hdead_beef || m_data_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL cpu_read: got rdata=%h addr=%h, required deadbeef 00000010",
               cpu_rdata, m_data_addr);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_forced_grant();
    int at;
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_byteen = 4'h0;
    run_aux(32'h10, 32'h0, 4'h0, 8, at);
    n_tests++;
    if (at !== 5) begin
      n_fail++;
      $display("FAIL forced_grant_cycle: got %0d, required 5", at);
    end
    // Held request right after a forced grant must starve again from zero.
    run_aux(32'h20, 32'h0, 4'h0, 8, at);
    n_tests++;
    if (at !== 5) begin
      n_fail++;
      $display("FAIL forced_grant_refill: got %0d, required 5", at);
    end
    aux_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_after_forced: got stall=%b, required 0", cpu_stall);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_aux_write();
    int at;
    run_aux(32'h20, 32'h0000_abcd, 4'b0011, 4, at);
    aux_valid = 1'b0;
    n_tests++;
    if (at !== 1) begin
      n_fail++;
      $display("FAIL aux_write_ready: got cycle %0d, required 1", at);
    end
    @(negedge clk);
    n_tests++;
    if (mem[8] !== 32'h0000_abcd || aux_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL aux_write_mem: got mem8=%h rvalid=%b, required 0000abcd 1", mem[8], aux_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int at;
    run_aux(32'h4010, 32'h0, 4'h0, 4, at);
    run_aux(32'h4010, 32'hffff_ffff, 4'hf, 4, at);
    aux_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[4] !== 32'hdead_beef) begin
      n_fail++;
      $display("FAIL oor_write_dropped: got mem4=%h, required deadbeef", mem[4]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int at;
    int total;
    total = 0;
    run_aux(32'h10, 32'h0, 4'h0, 4, at);          total += at;
    run_aux(32'h24, 32'h5a5a_0000, 4'b1100, 4, at); total += at;
    run_aux(32'h24, 32'h0, 4'h0, 4, at);          total += at;
    aux_valid = 1'b0;
    n_tests++;
    if (total !== 3) begin
      n_fail++;
      $display("FAIL b2b_ready: got %0d cycles for 3 accepts, required 3", total);
    end
    @(negedge clk);
    n_tests++;
    if (aux_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_last_rvalid: got %b, required 1", aux_rvalid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (aux_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rvalid_drop: got %b, required 0", aux_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int at;
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_byteen = 4'h0;
    aux_valid = 1'b1; aux_addr = 32'h30; aux_wdata = 32'h1234_5678; aux_byteen = 4'hf;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (aux_ready !== 1'b0 || cpu_stall !== 1'b0 || m_data_byteen !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got ready=%b stall=%b be=%h, required 0 0 0",
               aux_ready, cpu_stall, m_data_byteen);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[12] !== 32'h0 || aux_rvalid !== 1'b0 || aux_ready !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got mem12=%h rvalid=%b ready=%b stall=%b, required 0 0 0 0",
               mem[12], aux_rvalid, aux_ready, cpu_stall);
    end
    @(posedge clk); #1;
    run_aux(32'h30, 32'h1234_5678, 4'hf, 8, at);
    aux_valid = 1'b0;
    n_tests++;
    if (at !== 4) begin
      n_fail++;
      $display("FAIL reset_mid_rearb: got %0d further cycles, required 4", at);
    end
    @(negedge clk);
    n_tests++;
    if (mem[12] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h, required 12345678", mem[12]);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

`ifdef DM_ARB_STAT_EN
  task automatic test_stats();
    int at;
    cpu_req = 1'b0; aux_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_byteen = 4'h0;
    run_aux(32'h0, 32'h0, 4'h0, 8, at);
    run_aux(32'h0, 32'h0, 4'h0, 8, at);
    aux_valid = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stat_conflict !== 32'd10 || stat_forced !== 32'd2) begin
      n_fail++;
      $display("FAIL stats: got conflict=%0d forced=%0d, required 10 2", stat_conflict, stat_forced);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   <= 32'h0;
      shadow[i] = 32'h0;
    end
    test_reset();
    test_cpu_write();
    test_forced_grant();
    test_aux_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
`ifdef DM_ARB_STAT_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
